// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package reg_file_mp_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_ZERO   = 0;
  localparam int MAX_RD     = 4;

  // Low bit of field p in a flat bus of w-bit fields.
  function automatic int slice_lo(input int p, input int w);
    return p * w;
  endfunction
endpackage

// File: rtl/reg_file_mp_rd_port.sv
// One combinational read port: bypass priority mux (wr1 over wr0 over stored),
// x0 override and busy masking for registers being written this cycle.
module reg_file_mp_rd_port
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int ZERO_REG0 = 1,
  parameter int BYPASS    = 1
) (
  input  logic [ADDR_W-1:0]                      rd_addr,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]     mem_q,
  input  logic [(2**ADDR_W)-1:0]                 busy_q,
  input  logic                                   wr0_en,
  input  logic [ADDR_W-1:0]                      wr0_addr,
  input  logic [DATA_W-1:0]                      wr0_data,
  input  logic                                   wr1_en,
  input  logic [ADDR_W-1:0]                      wr1_addr,
  input  logic [DATA_W-1:0]                      wr1_data,
  output logic [DATA_W-1:0]                      rd_data,
  output logic                                   rd_busy
);
  logic is_zero;
  logic hit0;
  logic hit1;

  assign is_zero = (ZERO_REG0 != 0) && (rd_addr == ADDR_W'(REG_ZERO));
  assign hit0    = (BYPASS != 0) && wr0_en && (wr0_addr == rd_addr);
  assign hit1    = (BYPASS != 0) && wr1_en && (wr1_addr == rd_addr);

  always_comb begin
    rd_data = mem_q[rd_addr];
    if (is_zero)   rd_data = '0;
    else if (hit1) rd_data = wr1_data;
    else if (hit0) rd_data = wr0_data;
  end

  // A register written this cycle has its data forwarded, so it is no hazard.
  assign rd_busy = busy_q[rd_addr] & ~is_zero & ~(hit0 | hit1);
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD async read ports, two write ports (wr1 wins),
// optional write-to-read bypass, hardwired x0 and a per-register busy scoreboard.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG0 = 1,
  parameter int BYPASS    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_addr
);
  localparam int DEPTH = 2 ** ADDR_W;

  if (NUM_RD < 1 || NUM_RD > MAX_RD) begin : g_bad_num_rd
    $error("reg_file_mp: NUM_RD must be 1..4");
  end

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [DEPTH-1:0]             busy_q;
  logic                         wr0_ok;
  logic                         wr1_ok;
  logic                         issue_ok;

  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] a);
    return (ZERO_REG0 != 0) && (a == ADDR_W'(REG_ZERO));
  endfunction

  assign wr0_ok   = wr0_en && !is_zero_addr(wr0_addr);
  assign wr1_ok   = wr1_en && !is_zero_addr(wr1_addr);
  assign issue_ok = issue_en && !is_zero_addr(issue_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      if (wr0_ok) mem_q[wr0_addr] <= wr0_data;
      if (wr1_ok) mem_q[wr1_addr] <= wr1_data;
      // Issue beats a same-cycle writeback: the new producer owns the register.
      for (int r = 0; r < DEPTH; r++) begin
        if (issue_ok && issue_addr == ADDR_W'(r))
          busy_q[r] <= 1'b1;
        else if ((wr0_en && wr0_addr == ADDR_W'(r)) || (wr1_en && wr1_addr == ADDR_W'(r)))
          busy_q[r] <= 1'b0;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    reg_file_mp_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG0(ZERO_REG0),
      .BYPASS   (BYPASS)
    ) u_rd_port (
      .rd_addr (rd_addr[slice_lo(p, ADDR_W) +: ADDR_W]),
      .mem_q   (mem_q),
      .busy_q  (busy_q),
      .wr0_en  (wr0_en),
      .wr0_addr(wr0_addr),
      .wr0_data(wr0_data),
      .wr1_en  (wr1_en),
      .wr1_addr(wr1_addr),
      .wr1_data(wr1_data),
      .rd_data (rd_data[slice_lo(p, DATA_W) +: DATA_W]),
      .rd_busy (rd_busy[p])
    );
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a bypassing/zero-x0 4-port instance and a plain 2-port
// instance share stimulus and are checked against an array-based reference model.
module tb_reg_file_mp;
  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] rd_addr;
  logic        wr0_en, wr1_en, issue_en;
  logic [4:0]  wr0_addr, wr1_addr, issue_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [127:0] rd_data_a;
  logic [3:0]   rd_busy_a;
  logic [63:0]  rd_data_b;
  logic [1:0]   rd_busy_b;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state, index 0 = bypass/zero-x0 config, 1 = plain config.
  logic [31:0] m_mem  [2][32];
  logic        m_busy [2][32];
  bit          cfg_zero [2] = '{1'b1, 1'b0};
  bit          cfg_byp  [2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  reg_file_mp #(.NUM_RD(4), .ZERO_REG0(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .issue_en(issue_en), .issue_addr(issue_addr)
  );

  reg_file_mp #(.NUM_RD(2), .ZERO_REG0(0), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr[9:0]), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .issue_en(issue_en), .issue_addr(issue_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_data(input int c, input logic [4:0] a);
    if (cfg_zero[c] && a == 5'd0) return 32'd0;
    if (cfg_byp[c] && wr1_en && wr1_addr == a) return wr1_data;
    if (cfg_byp[c] && wr0_en && wr0_addr == a) return wr0_data;
    return m_mem[c][a];
  endfunction

  function automatic logic exp_busy(input int c, input logic [4:0] a);
    if (cfg_zero[c] && a == 5'd0) return 1'b0;
    if (cfg_byp[c] && ((wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a))) return 1'b0;
    return m_busy[c][a];
  endfunction

  task automatic check_all();
    for (int p = 0; p < 4; p++) begin
      check($sformatf("a_data%0d", p), rd_data_a[p*32 +: 32], exp_data(0, rd_addr[p*5 +: 5]));
      check($sformatf("a_busy%0d", p), {31'd0, rd_busy_a[p]}, {31'd0, exp_busy(0, rd_addr[p*5 +: 5])});
    end
    for (int p = 0; p < 2; p++) begin
      check($sformatf("b_data%0d", p), rd_data_b[p*32 +: 32], exp_data(1, rd_addr[p*5 +: 5]));
      check($sformatf("b_busy%0d", p), {31'd0, rd_busy_b[p]}, {31'd0, exp_busy(1, rd_addr[p*5 +: 5])});
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        for (int r = 0; r < 32; r++) begin
          m_mem[c][r]  = '0;
          m_busy[c][r] = 1'b0;
        end
      end else begin
        if (wr0_en && !(cfg_zero[c] && wr0_addr == 0)) m_mem[c][wr0_addr] = wr0_data;
        if (wr1_en && !(cfg_zero[c] && wr1_addr == 0)) m_mem[c][wr1_addr] = wr1_data;
        if (wr0_en) m_busy[c][wr0_addr] = 1'b0;
        if (wr1_en) m_busy[c][wr1_addr] = 1'b0;
        if (issue_en && !(cfg_zero[c] && issue_addr == 0)) m_busy[c][issue_addr] = 1'b1;
      end
    end
  endtask

  // Inputs are stable from the preceding falling edge; check, then advance one clock.
  task automatic tick();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    wr0_en = 0; wr1_en = 0; issue_en = 0;
  endtask

  task automatic set_rd(input logic [4:0] a0, a1, a2, a3);
    rd_addr = {a3, a2, a1, a0};
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    wr0_en = 1; wr0_addr = a; wr0_data = d;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    wr1_en = 1; wr1_addr = a; wr1_data = d;
  endtask

  task automatic issue(input logic [4:0] a);
    issue_en = 1; issue_addr = a;
  endtask

  initial begin
    rst = 1; rd_addr = '0; idle();
    wr0_addr = '0; wr1_addr = '0; issue_addr = '0; wr0_data = '0; wr1_data = '0;
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 32; r++) begin m_mem[c][r] = 'x; m_busy[c][r] = 1'bx; end
    @(negedge clk);
    tick(); tick();
    rst = 0;

    // Reset: preload, then reset with a write and issue in the reset cycle.
    wr0(5'd1, 32'd5); wr1(5'd2, 32'd5); tick(); idle();
    wr0(5'd5, 32'h16); issue(5'd9); tick(); idle();
    rst = 1; wr0(5'd4, 32'h77); issue(5'd4); tick(); idle(); rst = 0;
    set_rd(5'd1, 5'd2, 5'd5, 5'd4); #1;
    check("rst_x1", rd_data_a[31:0], 32'd0);
    check("rst_x5", rd_data_a[95:64], 32'd0);
    check("rst_x4_lost", rd_data_a[127:96], 32'd0);
    check("rst_busy", {28'd0, rd_busy_a}, 32'd0);
    set_rd(5'd9, 5'd4, 5'd0, 5'd0); #1;
    check("rst_busy_nb", {30'd0, rd_busy_b}, 32'd0);
    tick();

    // Write then read, with and without bypass.
    wr0(5'd5, 32'h16); set_rd(5'd5, 5'd5, 5'd5, 5'd5); #1;
    check("byp_x5", rd_data_a[31:0], 32'h16);
    check("nobyp_x5_old", rd_data_b[31:0], 32'd0);
    tick(); idle(); #1;
    check("next_x5_a", rd_data_a[31:0], 32'h16);
    check("next_x5_b", rd_data_b[31:0], 32'h16);
    tick();

    // Dual write collision: wr1 wins.
    wr0(5'd3, 32'hAAAA); wr1(5'd3, 32'h5555); set_rd(5'd3, 5'd3, 5'd3, 5'd3); #1;
    check("coll_byp", rd_data_a[31:0], 32'h5555);
    tick(); idle(); #1;
    check("coll_a", rd_data_a[31:0], 32'h5555);
    check("coll_b", rd_data_b[31:0], 32'h5555);
    tick();

    // x0 handling.
    wr1(5'd0, 32'h161); issue(5'd0); set_rd(5'd0, 5'd0, 5'd0, 5'd0); tick(); idle(); #1;
    check("x0_zero", rd_data_a[31:0], 32'd0);
    check("x0_busy", {31'd0, rd_busy_a[0]}, 32'd0);
    check("x0_plain", rd_data_b[31:0], 32'h161);
    tick();

    // Scoreboard.
    issue(5'd7); set_rd(5'd7, 5'd7, 5'd7, 5'd7); tick(); idle(); #1;
    check("sb_set", {31'd0, rd_busy_a[0]}, 32'd1);
    tick(); tick();
    wr0(5'd7, 32'h9); #1;
    check("sb_byp_busy", {31'd0, rd_busy_a[0]}, 32'd0);
    check("sb_byp_data", rd_data_a[31:0], 32'h9);
    check("sb_nobyp_busy", {31'd0, rd_busy_b[0]}, 32'd1);
    tick(); idle(); #1;
    check("sb_clr", {31'd0, rd_busy_b[0]}, 32'd0);
    issue(5'd7); wr1(5'd7, 32'h42); tick(); idle(); #1;
    check("sb_issue_wins", {31'd0, rd_busy_a[0]}, 32'd1);
    tick();

    // Four simultaneous reads.
    wr0(5'd1, 32'd5); wr1(5'd2, 32'd5); tick(); idle();
    wr0(5'd5, 32'h16); tick(); idle();
    set_rd(5'd1, 5'd2, 5'd1, 5'd5); #1;
    check("mp0", rd_data_a[31:0], 32'd5);
    check("mp1", rd_data_a[63:32], 32'd5);
    check("mp2", rd_data_a[95:64], 32'd5);
    check("mp3", rd_data_a[127:96], 32'h16);
    tick();

    // Randomized traffic on a small address window to force collisions.
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 49) == 0);
      wr0_en     = $urandom_range(0, 1);
      wr0_addr   = 5'($urandom_range(0, 7));
      wr0_data   = $urandom;
      wr1_en     = $urandom_range(0, 1);
      wr1_addr   = 5'($urandom_range(0, 7));
      wr1_data   = $urandom;
      issue_en   = $urandom_range(0, 1);
      issue_addr = 5'($urandom_range(0, 7));
      for (int p = 0; p < 4; p++) rd_addr[p*5 +: 5] = 5'($urandom_range(0, 8));
      tick();
    end
    rst = 0; idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
